chimpo_control: RTL and testbench
=================================

# chimpo_control

Multicycle control unit for the Chimpo 16-bit processor. It sits directly upstream of the datapath. Each cycle it decodes the 4-bit opcode `Op` and the ALU zero flag, steps a Moore-style state machine, and drives every datapath mux select and write strobe (`PCWrite`, `MemAddr`, `ALUSrcB`, `aluOpOut`, ...). It also reports `current_state` for the datapath bench to observe.

## Interface
Parameters:
- `PC_STEP`, 2: byte increment applied to PC in FETCH; drives the ALUSrcB constant select.

Ports:
- `CLK`  in  1  sole clock; rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Op`  in  4  opcode field, Instruction[15:12], taken from the instruction register.
- `alu_zero`  in  1  ALU zero flag; combinational from the datapath.
- `mem_err`  in  1  memory fault; sampled on the rising edge.
- `PCWrite`  out  1  PC load enable, already qualified with the branch condition.
- `IRWrite`  out  1  instruction register load.
- `MemRead`  out  1  memory read strobe.
- `MemWrite`  out  1  memory write strobe.
- `MemAddr`  out  2  address select: 0 = PC, 1 = ALUOut; 2 and 3 are unused and driven 0.
- `ALUSrcA`  out  1  ALU A select: 0 = PC, 1 = regoutA.
- `ALUSrcB`  out  3  ALU B select: 0 = regoutB, 1 = PC_STEP, 2 = sext(imm), 3 = sext(imm)<<1.
- `aluOpOut`  out  3  ALU function: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT.
- `PCSource`  out  2  PC input select: 0 = ALU result, 1 = ALUOut, 2 = jump target.
- `RegWrite`  out  1  register file write.
- `RegDst`  out  2  destination select: 0 = rd, 1 = rt, 2 = link register r15.
- `MemtoReg`  out  2  write-back data select: 0 = ALUOut, 1 = mdr, 2 = PC.
- `current_state`  out  4  state register, for observation only.
- `halted`  out  1  high in HALT or ERROR.

## Operation
- Opcodes:
  - R-type: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT.
  - 5 ADDI, 6 LW, 7 SW, 8 BEQ, 9 BNE, A JMP, B JAL, F HALT.
  - C, D and E are illegal.
- State encodings: 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 REX, 7 RWB, 8 IEX, 9 IWB, A BR, B JMP, C JAL, E HALT, F ERROR.
- Per-state outputs:
  - FETCH: MemRead, IRWrite, MemAddr=0, ALUSrcA=0, ALUSrcB=1, ADD, PCSource=0, PCWrite. Next: DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=3, ADD; this precomputes the branch target into ALUOut.
    - Op 0–4 → REX; 5 → IEX; 6, 7 → MEMADR; 8, 9 → BR; A → JMP; B → JAL; F → HALT.
    - Op C–E → ERROR.
  - MEMADR: ALUSrcA=1, ALUSrcB=2, ADD. Next: MEMRD for LW, MEMWR for SW.
  - MEMRD: MemRead, MemAddr=1. Next: MEMWB.
  - MEMWB: RegWrite, RegDst=1, MemtoReg=1. Next: FETCH.
  - MEMWR: MemWrite, MemAddr=1. Next: FETCH.
  - REX: ALUSrcA=1, ALUSrcB=0, aluOpOut=Op[2:0]. Next: RWB.
  - RWB: RegWrite, RegDst=0, MemtoReg=0. Next: FETCH.
  - IEX: ALUSrcA=1, ALUSrcB=2, ADD. Next: IWB.
  - IWB: RegWrite, RegDst=1, MemtoReg=0. Next: FETCH.
  - BR: ALUSrcA=1, ALUSrcB=0, SUB, PCSource=1.
    - PCWrite = alu_zero for BEQ, ~alu_zero for BNE.
    - Next: FETCH.
  - JMP: PCSource=2, PCWrite. Next: FETCH.
  - JAL: PCSource=2, PCWrite, RegWrite, RegDst=2, MemtoReg=2. Next: FETCH.
  - HALT and ERROR: all strobes low; state holds until reset.
- Any output not listed for a state is 0.
- `Op` is read only in DECODE and MEMADR. IRWrite is low in both, so Op is stable there.

## Timing
- Asynchronous reset: while `reset`=0, state=FETCH. All strobes (PCWrite, IRWrite, MemRead, MemWrite, RegWrite) are forced 0; selects take their FETCH values. `halted`=0.
- First fetch happens on the first rising edge after `reset` deasserts.
- Reset asserted mid-instruction aborts it immediately; no partial write strobe may reach the next edge.
- Outputs are decoded from the state register (Moore). The single exception is the branch PCWrite in BR, which is combinational from `alu_zero`.
- Cycles per instruction:
  - R-type, ADDI, SW: 4.
  - LW: 5.
  - BEQ, BNE, JMP, JAL: 3.
  - HALT: 2, then holds.
- `mem_err`=1 at a rising edge in FETCH, MEMRD or MEMWR → next state ERROR, overriding the normal transition.
  - The faulting cycle's strobes are still asserted; the datapath gates them itself.
  - `mem_err` is ignored in all other states.
- ERROR is sticky: only reset leaves it.

## Structure
- Package `chimpo_pkg` holds:
  - `state_t` enum with the exact 4-bit encodings above;
  - opcode localparams;
  - ALU op codes;
  - ALUSrcB, PCSource, MemAddr, RegDst and MemtoReg select constants.
- No sub-module. The block is one state register, a next-state block and an output-decode block.

## Test plan
- Reset held low 199 ns, then released → first edge: state FETCH→DECODE, PCWrite=1 and IRWrite=1 during FETCH.
- Op=6 (LW) → states 0,1,2,3,4,0. MemAddr=1 in state 3; RegWrite=1 with MemtoReg=1 in state 4.
- Op=8 with alu_zero=1 → PCWrite=1, PCSource=1 in BR. Repeat with alu_zero=0 → PCWrite=0. Op=9 gives the inverse results.
- Op=C in DECODE → ERROR (F), `halted`=1, and the state holds for 10 cycles.
- mem_err=1 during MEMRD → ERROR next cycle. Then reset=0 → state 0 and all strobes 0 asynchronously, before the next edge.
- Op=B (JAL) → 3 cycles, with RegWrite=1, RegDst=2, MemtoReg=2, PCWrite=1 in JAL. Op=F → HALT (E), and PCWrite stays 0 thereafter.

Source files
------------

// File: rtl/chimpo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chimpo_pkg
// Purpose  : Shared encodings for the Chimpo 16-bit multicycle control unit.
// Revision : 1.0 - initial release
// ============================================================================
package chimpo_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'h0,
        S_DECODE = 4'h1,
        S_MEMADR = 4'h2,
        S_MEMRD  = 4'h3,
        S_MEMWB  = 4'h4,
        S_MEMWR  = 4'h5,
        S_REX    = 4'h6,
        S_RWB    = 4'h7,
        S_IEX    = 4'h8,
        S_IWB    = 4'h9,
        S_BR     = 4'hA,
        S_JMP    = 4'hB,
        S_JAL    = 4'hC,
        S_HALT   = 4'hE,
        S_ERROR  = 4'hF
    } state_t;

    localparam logic [3:0] C_OP_ADD  = 4'h0;
    localparam logic [3:0] C_OP_SUB  = 4'h1;
    localparam logic [3:0] C_OP_AND  = 4'h2;
    localparam logic [3:0] C_OP_OR   = 4'h3;
    localparam logic [3:0] C_OP_SLT  = 4'h4;
    localparam logic [3:0] C_OP_ADDI = 4'h5;
    localparam logic [3:0] C_OP_LW   = 4'h6;
    localparam logic [3:0] C_OP_SW   = 4'h7;
    localparam logic [3:0] C_OP_BEQ  = 4'h8;
    localparam logic [3:0] C_OP_BNE  = 4'h9;
    localparam logic [3:0] C_OP_JMP  = 4'hA;
    localparam logic [3:0] C_OP_JAL  = 4'hB;
    localparam logic [3:0] C_OP_HALT = 4'hF;

    localparam logic [2:0] C_ALU_ADD = 3'd0;
    localparam logic [2:0] C_ALU_SUB = 3'd1;
    localparam logic [2:0] C_ALU_AND = 3'd2;
    localparam logic [2:0] C_ALU_OR  = 3'd3;
    localparam logic [2:0] C_ALU_SLT = 3'd4;

    localparam logic [2:0] C_SRCB_REGB = 3'd0;
    localparam logic [2:0] C_SRCB_STEP = 3'd1;
    localparam logic [2:0] C_SRCB_IMM  = 3'd2;
    localparam logic [2:0] C_SRCB_IMM2 = 3'd3;

    localparam logic [1:0] C_PCSRC_ALU    = 2'd0;
    localparam logic [1:0] C_PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] C_PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] C_MADDR_PC     = 2'd0;
    localparam logic [1:0] C_MADDR_ALUOUT = 2'd1;

    localparam logic [1:0] C_RDST_RD   = 2'd0;
    localparam logic [1:0] C_RDST_RT   = 2'd1;
    localparam logic [1:0] C_RDST_LINK = 2'd2;

    localparam logic [1:0] C_M2R_ALUOUT = 2'd0;
    localparam logic [1:0] C_M2R_MDR    = 2'd1;
    localparam logic [1:0] C_M2R_PC     = 2'd2;

endpackage : chimpo_pkg
`default_nettype wire

// File: rtl/chimpo_control.sv
`default_nettype none
// ============================================================================
// Module   : chimpo_control
// Purpose  : Moore multicycle control FSM driving the Chimpo datapath selects.
// Revision : 1.0 - initial release
// ============================================================================
module chimpo_control
    import chimpo_pkg::*;
#(
    parameter int PC_STEP = 2
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [3:0] Op,
    input  logic       alu_zero,
    input  logic       mem_err,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic [1:0] MemAddr,
    output logic       ALUSrcA,
    output logic [2:0] ALUSrcB,
    output logic [2:0] aluOpOut,
    output logic [1:0] PCSource,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [3:0] current_state,
    output logic       halted
);

    if (PC_STEP <= 0) begin : g_bad_step
        $error("chimpo_control: PC_STEP must be positive");
    end

    state_t     r_state;
    state_t     w_next_state;
    logic       r_is_bne;
    logic [2:0] r_rex_op;

    // Branch polarity and R-type function are latched in DECODE so later states never look at Op.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state  <= S_FETCH;
            r_is_bne <= 1'b0;
            r_rex_op <= C_ALU_ADD;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_DECODE) begin
                r_is_bne <= (Op == C_OP_BNE);
                r_rex_op <= Op[2:0];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                case (Op)
                    C_OP_ADD, C_OP_SUB, C_OP_AND,
                    C_OP_OR, C_OP_SLT:          w_next_state = S_REX;
                    C_OP_ADDI:                  w_next_state = S_IEX;
                    C_OP_LW, C_OP_SW:           w_next_state = S_MEMADR;
                    C_OP_BEQ, C_OP_BNE:         w_next_state = S_BR;
                    C_OP_JMP:                   w_next_state = S_JMP;
                    C_OP_JAL:                   w_next_state = S_JAL;
                    C_OP_HALT:                  w_next_state = S_HALT;
                    default:                    w_next_state = S_ERROR;
                endcase
            end
            S_MEMADR: w_next_state = (Op == C_OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next_state = S_MEMWB;
            S_REX:    w_next_state = S_RWB;
            S_IEX:    w_next_state = S_IWB;
            S_MEMWB, S_MEMWR, S_RWB, S_IWB,
            S_BR, S_JMP, S_JAL:   w_next_state = S_FETCH;
            S_HALT:   w_next_state = S_HALT;
            S_ERROR:  w_next_state = S_ERROR;
            default:  w_next_state = S_ERROR;
        endcase
        if (mem_err && ((r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR))) begin
            w_next_state = S_ERROR;
        end
    end

    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemAddr  = C_MADDR_PC;
        ALUSrcA  = 1'b0;
        ALUSrcB  = C_SRCB_REGB;
        aluOpOut = C_ALU_ADD;
        PCSource = C_PCSRC_ALU;
        RegWrite = 1'b0;
        RegDst   = C_RDST_RD;
        MemtoReg = C_M2R_ALUOUT;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                ALUSrcB = C_SRCB_STEP;
                PCWrite = 1'b1;
            end
            S_DECODE: ALUSrcB = C_SRCB_IMM2;
            S_MEMADR, S_IEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = C_SRCB_IMM;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                MemAddr = C_MADDR_ALUOUT;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                RegDst   = C_RDST_RT;
                MemtoReg = C_M2R_MDR;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                MemAddr  = C_MADDR_ALUOUT;
            end
            S_REX: begin
                ALUSrcA  = 1'b1;
                aluOpOut = r_rex_op;
            end
            S_RWB: RegWrite = 1'b1;
            S_IWB: begin
                RegWrite = 1'b1;
                RegDst   = C_RDST_RT;
            end
            S_BR: begin
                ALUSrcA  = 1'b1;
                aluOpOut = C_ALU_SUB;
                PCSource = C_PCSRC_ALUOUT;
                PCWrite  = r_is_bne ? ~alu_zero : alu_zero;
            end
            S_JMP: begin
                PCSource = C_PCSRC_JUMP;
                PCWrite  = 1'b1;
            end
            S_JAL: begin
                PCSource = C_PCSRC_JUMP;
                PCWrite  = 1'b1;
                RegWrite = 1'b1;
                RegDst   = C_RDST_LINK;
                MemtoReg = C_M2R_PC;
            end
            default: ;
        endcase
        // Strobes die the instant reset asserts, ahead of the state register update.
        if (!reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

    assign current_state = r_state;
    assign halted        = (r_state == S_HALT) || (r_state == S_ERROR);

endmodule : chimpo_control
`default_nettype wire

// File: tb/tb_chimpo_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_chimpo_control
// Purpose  : Self-checking bench for chimpo_control (table, corner cases, random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_chimpo_control;

    logic       CLK = 1'b0;
    logic       reset;
    logic [3:0] Op;
    logic       alu_zero;
    logic       mem_err;
    logic       PCWrite, IRWrite, MemRead, MemWrite, ALUSrcA, RegWrite, halted;
    logic [1:0] MemAddr, PCSource, RegDst, MemtoReg;
    logic [2:0] ALUSrcB, aluOpOut;
    logic [3:0] current_state;

    chimpo_control #(.PC_STEP(2)) dut (
        .CLK(CLK), .reset(reset), .Op(Op), .alu_zero(alu_zero), .mem_err(mem_err),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemAddr(MemAddr), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .aluOpOut(aluOpOut),
        .PCSource(PCSource), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .current_state(current_state), .halted(halted)
    );

    initial forever #5 CLK = ~CLK;

    typedef struct packed {
        logic       pcw;
        logic       irw;
        logic       mr;
        logic       mw;
        logic [1:0] ma;
        logic       sa;
        logic [2:0] sb;
        logic [2:0] aop;
        logic [1:0] pcs;
        logic       rw;
        logic [1:0] rd;
        logic [1:0] m2r;
        logic       halted;
    } out_t;

    typedef struct {
        logic [3:0] op;
        logic       zero;
        int         cpi;
        logic       last_pcw;
    } vec_t;

    typedef logic [3:0] st_q_t[$];

    out_t st_out[16];
    out_t rst_out;
    out_t dut_out;
    int   n_vec  = 0;
    int   n_fail = 0;

    assign dut_out = {PCWrite, IRWrite, MemRead, MemWrite, MemAddr, ALUSrcA, ALUSrcB,
                      aluOpOut, PCSource, RegWrite, RegDst, MemtoReg, halted};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction-level reference: the state walk each opcode takes from FETCH.
    function automatic st_q_t seq_of(input logic [3:0] op);
        st_q_t q;
        q.push_back(4'h0);
        q.push_back(4'h1);
        if (op <= 4'h4) begin
            q.push_back(4'h6); q.push_back(4'h7);
        end else begin
            case (op)
                4'h5: begin q.push_back(4'h8); q.push_back(4'h9); end
                4'h6: begin q.push_back(4'h2); q.push_back(4'h3); q.push_back(4'h4); end
                4'h7: begin q.push_back(4'h2); q.push_back(4'h5); end
                4'h8, 4'h9: q.push_back(4'hA);
                4'hA: q.push_back(4'hB);
                4'hB: q.push_back(4'hC);
                4'hF: q.push_back(4'hE);
                default: q.push_back(4'hF);
            endcase
        end
        return q;
    endfunction

    function automatic out_t exp_of(input logic [3:0] st, input logic [3:0] op, input logic zero);
        out_t e;
        e = st_out[st];
        if (st == 4'h6) e.aop = op[2:0];
        if (st == 4'hA) e.pcw = (op == 4'h8) ? zero : ~zero;
        return e;
    endfunction

    task automatic cycle_check(input logic [3:0] op, input logic zero, input logic merr,
                               input logic [3:0] exp_st, input string name);
        @(negedge CLK);
        Op = op; alu_zero = zero; mem_err = merr;
        #1;
        check({name, " state"}, {28'd0, current_state}, {28'd0, exp_st});
        check({name, " outs"}, {11'd0, dut_out}, {11'd0, exp_of(exp_st, op, zero)});
    endtask

    task automatic do_reset();
        @(negedge CLK);
        reset = 1'b0;
        #1;
        check("async rst state", {28'd0, current_state}, 32'd0);
        check("async rst outs", {11'd0, dut_out}, {11'd0, rst_out});
        @(posedge CLK);
        #2;
        mem_err = 1'b0;
        reset   = 1'b1;
    endtask

    task automatic run_instr(input logic [3:0] op, input logic zero, input logic allow_err);
        st_q_t q;
        logic  merr;
        q = seq_of(op);
        foreach (q[i]) begin
            merr = allow_err && ($urandom_range(0, 15) == 0);
            cycle_check(op, zero, merr, q[i], "rand");
            if (merr && (q[i] == 4'h0 || q[i] == 4'h3 || q[i] == 4'h5)) begin
                cycle_check(op, zero, 1'b0, 4'hF, "rand memerr");
                do_reset();
                return;
            end
        end
    endtask

    vec_t tbl[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1);
    end

    initial begin
        st_q_t q;
        reset = 1'b0; Op = 4'h0; alu_zero = 1'b0; mem_err = 1'b0;

        for (int i = 0; i < 16; i++) st_out[i] = '0;
        st_out[0].pcw = 1; st_out[0].irw = 1; st_out[0].mr = 1; st_out[0].sb = 3'd1;
        st_out[1].sb = 3'd3;
        st_out[2].sa = 1; st_out[2].sb = 3'd2;
        st_out[3].mr = 1; st_out[3].ma = 2'd1;
        st_out[4].rw = 1; st_out[4].rd = 2'd1; st_out[4].m2r = 2'd1;
        st_out[5].mw = 1; st_out[5].ma = 2'd1;
        st_out[6].sa = 1;
        st_out[7].rw = 1;
        st_out[8].sa = 1; st_out[8].sb = 3'd2;
        st_out[9].rw = 1; st_out[9].rd = 2'd1;
        st_out[10].sa = 1; st_out[10].aop = 3'd1; st_out[10].pcs = 2'd1;
        st_out[11].pcw = 1; st_out[11].pcs = 2'd2;
        st_out[12].pcw = 1; st_out[12].pcs = 2'd2; st_out[12].rw = 1;
        st_out[12].rd = 2'd2; st_out[12].m2r = 2'd2;
        st_out[14].halted = 1;
        st_out[15].halted = 1;
        rst_out = st_out[0];
        rst_out.pcw = 0; rst_out.irw = 0; rst_out.mr = 0;

        tbl = '{
            '{4'h0, 1'b0, 4, 1'b0}, '{4'h1, 1'b1, 4, 1'b0}, '{4'h2, 1'b0, 4, 1'b0},
            '{4'h3, 1'b0, 4, 1'b0}, '{4'h4, 1'b1, 4, 1'b0}, '{4'h5, 1'b0, 4, 1'b0},
            '{4'h6, 1'b0, 5, 1'b0}, '{4'h7, 1'b0, 4, 1'b0}, '{4'h8, 1'b1, 3, 1'b1},
            '{4'h8, 1'b0, 3, 1'b0}, '{4'h9, 1'b1, 3, 1'b0}, '{4'h9, 1'b0, 3, 1'b1},
            '{4'hA, 1'b0, 3, 1'b1}, '{4'hB, 1'b0, 3, 1'b1}
        };

        #50;
        check("reset state", {28'd0, current_state}, 32'd0);
        check("reset outs", {11'd0, dut_out}, {11'd0, rst_out});
        #149 reset = 1'b1;

        foreach (tbl[v]) begin
            q = seq_of(tbl[v].op);
            for (int c = 0; c < tbl[v].cpi; c++) begin
                cycle_check(tbl[v].op, tbl[v].zero, 1'b0, (c < q.size()) ? q[c] : 4'hD, "table");
            end
            check("table last pcw", {31'd0, PCWrite}, {31'd0, tbl[v].last_pcw});
        end
        cycle_check(4'h0, 1'b0, 1'b0, 4'h0, "table cpi");
        cycle_check(4'h0, 1'b0, 1'b0, 4'h1, "table cpi");
        cycle_check(4'h0, 1'b0, 1'b0, 4'h6, "table cpi");
        cycle_check(4'h0, 1'b0, 1'b0, 4'h7, "table cpi");

        // Illegal opcode: sticky ERROR, mem_err there ignored.
        cycle_check(4'hC, 1'b0, 1'b0, 4'h0, "illegal");
        cycle_check(4'hC, 1'b0, 1'b0, 4'h1, "illegal");
        for (int i = 0; i < 10; i++) begin
            cycle_check(4'hC, 1'($urandom), 1'($urandom), 4'hF, "error hold");
        end
        do_reset();

        // Memory fault during MEMRD, then asynchronous recovery.
        cycle_check(4'h6, 1'b0, 1'b0, 4'h0, "memerr");
        cycle_check(4'h6, 1'b0, 1'b0, 4'h1, "memerr");
        cycle_check(4'h6, 1'b0, 1'b0, 4'h2, "memerr");
        cycle_check(4'h6, 1'b0, 1'b1, 4'h3, "memerr rd");
        cycle_check(4'h6, 1'b0, 1'b0, 4'hF, "memerr err");
        do_reset();

        // Reset landing inside MEMWB must kill RegWrite immediately.
        cycle_check(4'h6, 1'b0, 1'b0, 4'h0, "midrst");
        cycle_check(4'h6, 1'b0, 1'b0, 4'h1, "midrst");
        cycle_check(4'h6, 1'b0, 1'b0, 4'h2, "midrst");
        cycle_check(4'h6, 1'b0, 1'b0, 4'h3, "midrst");
        cycle_check(4'h6, 1'b0, 1'b0, 4'h4, "midrst wb");
        #1 reset = 1'b0;
        #1;
        check("midrst regwrite", {31'd0, RegWrite}, 32'd0);
        check("midrst state", {28'd0, current_state}, 32'd0);
        @(posedge CLK);
        #2 reset = 1'b1;

        // HALT holds with PCWrite low.
        cycle_check(4'hF, 1'b0, 1'b0, 4'h0, "halt");
        cycle_check(4'hF, 1'b0, 1'b0, 4'h1, "halt");
        for (int i = 0; i < 5; i++) begin
            cycle_check(4'hF, 1'($urandom), 1'($urandom), 4'hE, "halt hold");
        end
        do_reset();

        for (int i = 0; i < 150; i++) begin
            run_instr(4'($urandom_range(0, 11)), 1'($urandom), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_chimpo_control
`default_nettype wire
